// File: rtl/histogram_accum_engine.sv
// Per-frame histogram engine: accumulates pixel bin indices into an internal
// RAM through a two-stage read-modify-write pipeline with same-bin forwarding,
// then streams the finished histogram out (clear-on-read) over valid/ready.
module histogram_accum_engine #(
  parameter int BIN_BITS  = 8,
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 pix_valid,
  input  logic [BIN_BITS-1:0]  pix_data,
  output logic                 hist_valid,
  input  logic                 hist_ready,
  output logic [BIN_BITS-1:0]  hist_bin,
  output logic [CNT_WIDTH-1:0] hist_count,
  output logic                 hist_last,
  output logic                 busy,
  output logic                 overflow,
  output logic                 pix_drop
);

  localparam int                   DEPTH    = 1 << BIN_BITS;
  localparam logic [BIN_BITS-1:0]  LAST_BIN = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DRAIN, READOUT} state_t;

  state_t               state;
  logic [BIN_BITS-1:0]  clr_addr;
  logic                 drain_cnt;

  logic [CNT_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0] ram_q;
  logic                 we;
  logic [BIN_BITS-1:0]  wa;
  logic [CNT_WIDTH-1:0] wd;
  logic [BIN_BITS-1:0]  ra;

  // S1 stage and the record of the previous cycle's increment write
  logic                 s1_valid;
  logic [BIN_BITS-1:0]  s1_bin;
  logic                 fwd_valid;
  logic [BIN_BITS-1:0]  fwd_bin;
  logic [CNT_WIDTH-1:0] fwd_data;

  logic                 start_ok;
  logic                 pix_accept;
  logic                 pix_reject;
  logic                 accept;
  logic [CNT_WIDTH-1:0] base;
  logic [CNT_WIDTH-1:0] new_cnt;
  logic                 at_max;

  assign start_ok   = (state == IDLE) && frame_start;
  assign pix_accept = pix_valid && ((state == ACCUM) || start_ok);
  assign pix_reject = pix_valid && ((state == CLEAR) || (state == DRAIN) || (state == READOUT));
  assign accept     = hist_valid && hist_ready;
  assign busy       = (state == CLEAR) || (state == DRAIN) || (state == READOUT);
  // Count is only meaningful while a word is offered; keep it quiet otherwise.
  assign hist_count = hist_valid ? ram_q : '0;

  // Increment path: the RAM read issued one cycle earlier misses a write to the
  // same bin made in the previous cycle, so that value is forwarded instead.
  always_comb begin
    base    = (fwd_valid && (fwd_bin == s1_bin)) ? fwd_data : ram_q;
    at_max  = (base == CNT_MAX);
    new_cnt = base + CNT_WIDTH'(1);
    if (at_max) new_cnt = SATURATE ? base : '0;
  end

  // Single write port arbitration: clearing sweep, clear-on-read, or increment.
  always_comb begin
    we = 1'b0;
    wa = s1_bin;
    wd = new_cnt;
    case (state)
      CLEAR: begin
        we = 1'b1;
        wa = clr_addr;
        wd = '0;
      end
      READOUT: begin
        we = accept;
        wa = hist_bin;
        wd = '0;
      end
      default: we = s1_valid;
    endcase
  end

  // Read address: pixel bin while counting; during readout, read ahead to the
  // word that will be on the port next cycle (re-read the same bin on a stall).
  always_comb begin
    ra = pix_data;
    if (state == READOUT) begin
      if (!hist_valid) ra = '0;
      else if (accept) ra = hist_bin + BIN_BITS'(1);
      else             ra = hist_bin;
    end
  end

  // Histogram storage write port.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Synchronous RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_q <= '0;
    else        ram_q <= mem[ra];
  end

  // RMW pipeline registers and forwarding record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      fwd_valid <= 1'b0;
      fwd_bin   <= '0;
      fwd_data  <= '0;
    end else begin
      s1_valid  <= pix_accept;
      s1_bin    <= pix_data;
      fwd_valid <= s1_valid;
      fwd_bin   <= s1_bin;
      fwd_data  <= new_cnt;
    end
  end

  // Sequencing FSM with registered readout outputs and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      drain_cnt  <= 1'b0;
      hist_valid <= 1'b0;
      hist_bin   <= '0;
      hist_last  <= 1'b0;
      overflow   <= 1'b0;
      pix_drop   <= 1'b0;
    end else begin
      if (start_ok) begin
        overflow <= 1'b0;
        pix_drop <= 1'b0;
      end else begin
        if (s1_valid && at_max) overflow <= 1'b1;
        if (pix_reject)         pix_drop <= 1'b1;
      end
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + BIN_BITS'(1);
          if (clr_addr == LAST_BIN) state <= IDLE;
        end
        IDLE: begin
          if (frame_start) state <= ACCUM;
        end
        ACCUM: begin
          if (frame_end) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= READOUT;
        end
        READOUT: begin
          if (!hist_valid) begin
            hist_valid <= 1'b1;
            hist_bin   <= '0;
            hist_last  <= 1'b0;
          end else if (accept) begin
            if (hist_last) begin
              hist_valid <= 1'b0;
              hist_last  <= 1'b0;
              hist_bin   <= '0;
              state      <= IDLE;
            end else begin
              hist_bin  <= hist_bin + BIN_BITS'(1);
              hist_last <= ((hist_bin + BIN_BITS'(1)) == LAST_BIN);
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_accum_engine.sv
// Self-checking bench for histogram_accum_engine: table-driven frames, random
// frames against a bin-count model, backpressure, drops, overflow and resets.
module tb_histogram_accum_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        frame_start, frame_end, pix_valid, hist_ready;
  logic [7:0]  pix_data;
  logic        hist_valid, hist_last, busy, overflow, pix_drop;
  logic [7:0]  hist_bin;
  logic [31:0] hist_count;

  // Small 8-bin, 4-bit-count instances for overflow behaviour
  logic        s_frame_start, s_frame_end, s_pix_valid, s_hist_ready;
  logic [2:0]  s_pix_data;
  logic        sa_hist_valid, sa_hist_last, sa_busy, sa_overflow, sa_pix_drop;
  logic [2:0]  sa_hist_bin;
  logic [3:0]  sa_hist_count;
  logic        wr_hist_valid, wr_hist_last, wr_busy, wr_overflow, wr_pix_drop;
  logic [2:0]  wr_hist_bin;
  logic [3:0]  wr_hist_count;

  histogram_accum_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .hist_valid(hist_valid),
    .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
    .hist_last(hist_last), .busy(busy), .overflow(overflow), .pix_drop(pix_drop)
  );

  histogram_accum_engine #(.BIN_BITS(3), .CNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .frame_end(s_frame_end),
    .pix_valid(s_pix_valid), .pix_data(s_pix_data), .hist_valid(sa_hist_valid),
    .hist_ready(s_hist_ready), .hist_bin(sa_hist_bin), .hist_count(sa_hist_count),
    .hist_last(sa_hist_last), .busy(sa_busy), .overflow(sa_overflow), .pix_drop(sa_pix_drop)
  );

  histogram_accum_engine #(.BIN_BITS(3), .CNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .frame_end(s_frame_end),
    .pix_valid(s_pix_valid), .pix_data(s_pix_data), .hist_valid(wr_hist_valid),
    .hist_ready(s_hist_ready), .hist_bin(wr_hist_bin), .hist_count(wr_hist_count),
    .hist_last(wr_hist_last), .busy(wr_busy), .overflow(wr_overflow), .pix_drop(wr_pix_drop)
  );

  int errors = 0;
  int checks = 0;

  longint unsigned model [256];   // expected count per bin for the current frame
  longint unsigned got   [256];   // counts observed in the last readout
  int              pq    [$];     // pixel values for the next frame

  typedef struct {
    int n;
    int pix [8];
    bit gap;
    int b0; int c0;
    int b1; int c1;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each accepted pixel adds one to its bin, clamped at 2^32-1.
  task automatic model_add(input int b);
    if (model[b] < 64'hFFFF_FFFF) model[b] = model[b] + 1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 0;
  endtask

  // Release-to-idle: number of clock edges while busy stays high.
  task automatic check_clear(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (busy && n < 1000);
    chk(name, n, 256);
  endtask

  // Sends the queued pixels as one frame; frame_end rides on the last pixel.
  // Returns mid-cycle t+1, where t is the cycle frame_end was sampled.
  task automatic do_frame(input bit gap, input bit combine);
    bit first;
    int v;
    @(negedge clk);
    frame_start = 1'b1;
    if (combine && pq.size() >= 2) begin
      v = pq.pop_front();
      pix_valid = 1'b1;
      pix_data  = v[7:0];
      model_add(v);
    end
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    chk("flags_cleared_on_start", {overflow, pix_drop}, 64'd0);
    first = 1'b1;
    if (pq.size() == 0) begin
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
    end
    while (pq.size() > 0) begin
      if (gap && !first) @(negedge clk);
      first     = 1'b0;
      v         = pq.pop_front();
      pix_valid = 1'b1;
      pix_data  = v[7:0];
      model_add(v);
      frame_end = (pq.size() == 0);
      @(negedge clk);
      pix_valid = 1'b0;
      frame_end = 1'b0;
    end
  endtask

  // Consumes a full readout, checking order, counts, hist_last and stability.
  task automatic readout(input bit rnd, input int exp_lat, input int drop_at);
    int lat, bin, cyc;
    bit ok, accepted;
    lat = 1;
    while (!hist_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, exp_lat);
    bin = 0;
    cyc = 0;
    while (bin < 256 && cyc < 3000) begin
      ok = hist_valid && (hist_bin == bin[7:0]) && (hist_last == (bin == 255)) &&
           (hist_count == model[bin][31:0]);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL readout_word: got valid=%0b bin=%0d count=%0d last=%0b expected valid=1 bin=%0d count=%0d last=%0b",
                 hist_valid, hist_bin, hist_count, hist_last, bin, model[bin], (bin == 255));
        if (!hist_valid) break;
      end
      got[bin]   = hist_count;
      pix_valid  = (cyc == drop_at);
      pix_data   = 8'h37;
      hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      accepted   = hist_valid && hist_ready;
      @(negedge clk);
      pix_valid = 1'b0;
      if (accepted) bin++;
      cyc++;
    end
    hist_ready = 1'b1;
    chk("readout_transfers", bin, 256);
    chk("idle_after_last", {busy, hist_valid}, 64'd0);
    $display("readout done: %0d words in %0d cycles", bin, cyc);
    model_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] sa_got [8];
    logic [3:0] wr_got [8];
    int n;
    int v;

    rst_n = 1'b0;
    frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = 0; hist_ready = 1;
    s_frame_start = 0; s_frame_end = 0; s_pix_valid = 0; s_pix_data = 0; s_hist_ready = 1;
    model_clear();

    vecs[0] = '{n: 3, pix: '{16, 16, 16, 0, 0, 0, 0, 0}, gap: 0, b0: 16, c0: 3, b1: 55, c1: 0};
    vecs[1] = '{n: 6, pix: '{5, 5, 6, 5, 5, 5, 0, 0}, gap: 0, b0: 5, c0: 5, b1: 6, c1: 1};
    vecs[2] = '{n: 6, pix: '{5, 5, 6, 5, 5, 5, 0, 0}, gap: 1, b0: 5, c0: 5, b1: 6, c1: 1};
    vecs[3] = '{n: 5, pix: '{7, 8, 7, 8, 7, 0, 0, 0}, gap: 1, b0: 7, c0: 3, b1: 8, c1: 2};
    vecs[4] = '{n: 8, pix: '{255, 255, 0, 0, 255, 0, 255, 255}, gap: 0, b0: 255, c0: 5, b1: 0, c1: 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, hist_valid, hist_last, overflow, pix_drop, hist_bin, hist_count}, {1'b1, 44'd0});
    rst_n = 1'b1;
    check_clear("clear_cycles_after_reset");
    chk("idle_outputs", {busy, hist_valid, overflow, pix_drop}, 64'd0);

    // Overflow in 4-bit counters: 20 pixels into bin 1
    @(negedge clk); s_frame_start = 1'b1;
    @(negedge clk); s_frame_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_pix_valid = 1'b1; s_pix_data = 3'd1; s_frame_end = (i == 19);
      @(negedge clk);
    end
    s_pix_valid = 1'b0; s_frame_end = 1'b0;
    for (int i = 0; i < 8; i++) begin sa_got[i] = 4'hA; wr_got[i] = 4'hA; end
    for (int c = 0; c < 40; c++) begin
      if (sa_hist_valid) sa_got[sa_hist_bin] = sa_hist_count;
      if (wr_hist_valid) wr_got[wr_hist_bin] = wr_hist_count;
      @(negedge clk);
    end
    chk("sat_bin1_count", sa_got[1], 15);
    chk("wrap_bin1_count", wr_got[1], 20 % 16);
    chk("sat_bin0_count", sa_got[0], 0);
    chk("overflow_flags_set", {sa_overflow, wr_overflow}, 2'b11);
    @(negedge clk); s_frame_start = 1'b1;
    @(negedge clk); s_frame_start = 1'b0;
    chk("overflow_flags_cleared", {sa_overflow, wr_overflow}, 2'b00);
    s_frame_end = 1'b1;
    @(negedge clk); s_frame_end = 1'b0;
    $display("overflow frame done: sat=%0d wrap=%0d", sa_got[1], wr_got[1]);

    // Single-bin frame with a dropped pixel during readout
    for (int i = 0; i < 1000; i++) pq.push_back(8'h37);
    do_frame(1'b0, 1'b0);
    readout(1'b0, 4, 100);
    chk("single_bin_count", got[8'h37], 1000);
    chk("single_bin_neighbour", got[8'h38], 0);
    chk("pix_drop_set", pix_drop, 1);

    // Table-driven frames with random backpressure
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) pq.push_back(vecs[k].pix[i]);
      do_frame(vecs[k].gap, 1'b0);
      readout(1'b1, 4, -1);
      chk($sformatf("vec%0d_bin%0d", k, vecs[k].b0), got[vecs[k].b0], vecs[k].c0);
      chk($sformatf("vec%0d_bin%0d", k, vecs[k].b1), got[vecs[k].b1], vecs[k].c1);
    end

    // Random frames against the model
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(20, 300);
      for (int i = 0; i < n; i++) begin
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        pq.push_back(v);
      end
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      readout(1'b1, 4, $urandom_range(0, 200));
      chk("random_frame_drop_flag", pix_drop, 1);
    end

    // Reset in the middle of a readout
    for (int i = 0; i < 4; i++) pq.push_back(8'h22);
    do_frame(1'b0, 1'b0);
    n = 0;
    while (!hist_valid && n < 20) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    pix_valid = 1'b1; pix_data = 8'h03;
    @(negedge clk); pix_valid = 1'b0;
    chk("drop_flag_mid_readout", {hist_valid, pix_drop}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_mid_readout", {busy, hist_valid, hist_last, overflow, pix_drop, hist_bin, hist_count}, {1'b1, 44'd0});
    @(negedge clk); rst_n = 1'b1;
    check_clear("clear_cycles_after_readout_reset");
    model_clear();

    // Reset in the middle of accumulation; the next frame starts from zero
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pix_valid = 1'b1; pix_data = 8'h37;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_mid_accum", {busy, hist_valid, hist_last, overflow, pix_drop, hist_bin, hist_count}, {1'b1, 44'd0});
    pix_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_clear("clear_cycles_after_accum_reset");
    for (int i = 0; i < 5; i++) pq.push_back(8'h37);
    pq.push_back(8'h99); pq.push_back(8'h99);
    do_frame(1'b0, 1'b1);
    readout(1'b1, 4, -1);
    chk("post_reset_bin37", got[8'h37], 5);
    chk("post_reset_bin99", got[8'h99], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
